cmos_pattern_gen: RTL

Synthetic DVP camera source that drives the same vsync/href/pixel interface the camera capture path consumes, so the capture, DDR write and display chain can be brought up and regression-tested without a sensor. It sits in the camera clock domain in place of the sensor pins. It emits frames of programmable geometry carrying one of four deterministic test patterns. The on-chip analyzer probes it at cmos_vsync / cmos_href.

---
 rtl/cmos_pattern_gen_if.sv | 21 ++
 rtl/cmos_pattern_gen.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/cmos_pattern_gen_if.sv
// DVP camera-side bundle: run/pattern controls in, vsync/href/pixel and frame status out.
// The generator uses the master modport; a capture path or test harness uses slave.
interface cmos_pattern_gen_if;
    logic        enable_i;
    logic [1:0]  pattern_sel_i;
    logic        cmos_vsync_o;
    logic        cmos_href_o;
    logic [15:0] cmos_data_o;
    logic        frame_done_o;
    logic [15:0] frame_cnt_o;

    modport master (
        input  enable_i, pattern_sel_i,
        output cmos_vsync_o, cmos_href_o, cmos_data_o, frame_done_o, frame_cnt_o
    );

    modport slave (
        output enable_i, pattern_sel_i,
        input  cmos_vsync_o, cmos_href_o, cmos_data_o, frame_done_o, frame_cnt_o
    );
endinterface

// File: rtl/cmos_pattern_gen.sv
// Synthetic DVP camera source: programmable frame geometry carrying one of four test patterns.
// Define CMOS_GEN_BYTE_MODE_EN for sensor-style 8-bit output (high byte then low byte per pixel).
module cmos_pattern_gen #(
    parameter int H_ACTIVE  = 1024,
    parameter int H_BLANK   = 64,
    parameter int V_ACTIVE  = 768,
    parameter int VSYNC_LEN = 16,
    parameter int V_BACK    = 2,
    parameter int V_FRONT   = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    cmos_pattern_gen_if.master bus
);
    // state    | meaning
    // S_IDLE   | stopped; waits for enable_i
    // S_VSYNC  | vsync high for VSYNC_LEN cycles
    // S_VBACK  | V_BACK blank lines after vsync
    // S_ACTIVE | V_ACTIVE lines: href for the active part, then blanking
    // S_VFRONT | V_FRONT blank lines; the frame ends on the last cycle

`ifdef CMOS_GEN_BYTE_MODE_EN
    localparam int HREF_LEN = 2 * H_ACTIVE;
`else
    localparam int HREF_LEN = H_ACTIVE;
`endif
    localparam int H_TOTAL = HREF_LEN + H_BLANK;
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int V_MAX0  = (V_ACTIVE > V_BACK) ? V_ACTIVE : V_BACK;
    localparam int V_MAX   = (V_MAX0 > V_FRONT) ? V_MAX0 : V_FRONT;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_MAX + 1);
    localparam int TW      = $clog2(VSYNC_LEN + 1);
    localparam int BW      = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] HREF_END = HW'(HREF_LEN);
    localparam logic [TW-1:0] T_LAST   = TW'(VSYNC_LEN - 1);
    localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

    state_t        state, state_n;
    logic [TW-1:0] tmr, tmr_n;
    logic [HW-1:0] h_cnt, h_n;
    logic [VW-1:0] v_cnt, v_n, v_last;
    logic [BW-1:0] bar_cnt, bar_cnt_n;
    logic [2:0]    bar_idx, bar_idx_n;
    logic [1:0]    pat, pat_n;
    logic          frame_end, in_href, pix_step, h_end;

    logic [15:0]   x, pix, data_d, cnt_d;
    logic [7:0]    y;
    logic          vsync_d;
    logic          vsync_q, href_q, done_q;
    logic [15:0]   data_q, frame_cnt_q;

    assign h_end   = (h_cnt == H_LAST);
    assign in_href = (state == S_ACTIVE) && (h_cnt < HREF_END);
`ifdef CMOS_GEN_BYTE_MODE_EN
    assign pix_step = in_href & h_cnt[0];
`else
    assign pix_step = in_href;
`endif

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return 16'hFFFF;
            3'd1:    return 16'hFFE0;
            3'd2:    return 16'h07FF;
            3'd3:    return 16'h07E0;
            3'd4:    return 16'hF81F;
            3'd5:    return 16'hF800;
            3'd6:    return 16'h001F;
            default: return 16'h0000;
        endcase
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            tmr     <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
            bar_cnt <= '0;
            bar_idx <= '0;
            pat     <= '0;
        end else begin
            state   <= state_n;
            tmr     <= tmr_n;
            h_cnt   <= h_n;
            v_cnt   <= v_n;
            bar_cnt <= bar_cnt_n;
            bar_idx <= bar_idx_n;
            pat     <= pat_n;
        end
    end

    always_comb begin
        state_n   = state;
        tmr_n     = tmr;
        h_n       = h_cnt;
        v_n       = v_cnt;
        bar_cnt_n = bar_cnt;
        bar_idx_n = bar_idx;
        pat_n     = pat;
        frame_end = 1'b0;
        v_last    = '0;
        case (state)
            S_IDLE: begin
                tmr_n = '0;
                if (bus.enable_i) begin
                    state_n = S_VSYNC;
                    pat_n   = bus.pattern_sel_i;
                end
            end
            S_VSYNC: begin
                tmr_n = tmr + TW'(1);
                if (tmr == T_LAST) begin
                    state_n   = (V_BACK > 0) ? S_VBACK : S_ACTIVE;
                    h_n       = '0;
                    v_n       = '0;
                    bar_cnt_n = '0;
                    bar_idx_n = '0;
                end
            end
            default: begin
                v_last = (state == S_VBACK)  ? VW'(V_BACK - 1) :
                         (state == S_ACTIVE) ? VW'(V_ACTIVE - 1) : VW'(V_FRONT - 1);
                h_n = h_end ? '0 : h_cnt + HW'(1);
                // bar counter replaces an x / BAR_W divide; bar_idx wraps 7 -> 0 at line end
                if (pix_step) begin
                    if (bar_cnt == BAR_LAST) begin
                        bar_cnt_n = '0;
                        bar_idx_n = bar_idx + 3'd1;
                    end else begin
                        bar_cnt_n = bar_cnt + BW'(1);
                    end
                end
                if (h_end) begin
                    bar_cnt_n = '0;
                    bar_idx_n = '0;
                    v_n       = v_cnt + VW'(1);
                    if (v_cnt == v_last) begin
                        v_n = '0;
                        if (state == S_VBACK) begin
                            state_n = S_ACTIVE;
                        end else if (state == S_ACTIVE && V_FRONT > 0) begin
                            state_n = S_VFRONT;
                        end else begin
                            frame_end = 1'b1;
                        end
                    end
                end
                if (frame_end) begin
                    tmr_n = '0;
                    if (bus.enable_i) begin
                        state_n = S_VSYNC;
                        pat_n   = bus.pattern_sel_i;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
        endcase
    end

    always_comb begin
`ifdef CMOS_GEN_BYTE_MODE_EN
        x = 16'(h_cnt >> 1);
`else
        x = 16'(h_cnt);
`endif
        y = 8'(v_cnt);
        unique case (pat)
            2'd0:    pix = bar_color(bar_idx);
            2'd1:    pix = x;
            2'd2:    pix = (x[3] ^ y[3]) ? 16'hFFFF : 16'h0000;
            default: pix = {frame_cnt_q[7:0], y};
        endcase
        data_d = 16'h0000;
        if (in_href) begin
`ifdef CMOS_GEN_BYTE_MODE_EN
            data_d = {8'h00, (h_cnt[0] ? pix[7:0] : pix[15:8])};
`else
            data_d = pix;
`endif
        end
        vsync_d = (state == S_VSYNC);
        cnt_d   = frame_cnt_q + {15'd0, frame_end};
    end

    // every output comes straight from a flop, one cycle behind the FSM
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vsync_q     <= 1'b0;
            href_q      <= 1'b0;
            data_q      <= '0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            vsync_q     <= vsync_d;
            href_q      <= in_href;
            data_q      <= data_d;
            done_q      <= frame_end;
            frame_cnt_q <= cnt_d;
        end
    end

    assign bus.cmos_vsync_o = vsync_q;
    assign bus.cmos_href_o  = href_q;
    assign bus.cmos_data_o  = data_q;
    assign bus.frame_done_o = done_q;
    assign bus.frame_cnt_o  = frame_cnt_q;
endmodule
